// File: rtl/mem_arbiter.sv
// Memory arbiter: serves instruction-fetch and data requests over one single-port RAM
// with a req/ack handshake. Define IBUF_EN to add a one-entry instruction buffer.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

    state_t            state_q, state_d;
    grant_t            grant_q, last_grant_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, iload_q, dload_q;
    logic              d_pend, pick_data, pick_instr, buf_hit, grant_en, ack_en;

    // Under contention the stream that did not win last time gets the RAM.
    assign d_pend     = dren | dwen;
    assign pick_data  = d_pend & (~iren | (last_grant_q != GRANT_DATA));
    assign pick_instr = iren & ~pick_data;
    assign grant_en   = (state_q == IDLE) & (pick_data | pick_instr);
    assign ack_en     = ((state_q == DACC) | (state_q == IACC)) & ram_ack;

`ifdef IBUF_EN
    logic              buf_valid_q;
    logic [ADDR_W-3:0] buf_tag_q;
    logic [DATA_W-1:0] buf_word_q;

    assign buf_hit = iren & ~d_pend & buf_valid_q & (buf_tag_q == iaddr[ADDR_W-1:2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_word_q  <= '0;
        end else if ((state_q == IACC) && ram_ack) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= addr_q[ADDR_W-1:2];
            buf_word_q  <= ram_rdata;
        end else if (grant_en && pick_data && dwen && (daddr[ADDR_W-1:2] == buf_tag_q)) begin
            buf_valid_q <= 1'b0;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        ihit    = 1'b0;
        dhit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_data)       state_d = DACC;
                else if (pick_instr) state_d = buf_hit ? RESP : IACC;
            end
            DACC: begin
                ram_wen = write_q;
                ram_ren = ~write_q;
                if (ram_ack) state_d = RESP;
            end
            IACC: begin
                ram_ren = 1'b1;
                if (ram_ack) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                // A hit is only issued if the requester still wants this exact address.
                if (grant_q == GRANT_DATA) dhit = (write_q ? dwen : dren) && (daddr == addr_q);
                else                       ihit = iren && (iaddr == addr_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_q      <= GRANT_INSTR;
            last_grant_q <= GRANT_INSTR;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            iload_q      <= '0;
            dload_q      <= '0;
        end else begin
            if (grant_en) begin
                grant_q      <= pick_data ? GRANT_DATA : GRANT_INSTR;
                last_grant_q <= pick_data ? GRANT_DATA : GRANT_INSTR;
                write_q      <= pick_data & dwen;
                addr_q       <= pick_data ? daddr : iaddr;
                if (pick_data) wdata_q <= dstore;
            end
            if (ack_en) rdata_q <= ram_rdata;
`ifdef IBUF_EN
            if (grant_en && buf_hit) rdata_q <= buf_word_q;
`endif
            if (ihit)             iload_q <= rdata_q;
            if (dhit && !write_q) dload_q <= rdata_q;
        end
    end

    // Load outputs expose the captured word only in the hit cycle, so a flushed
    // fetch never disturbs the value the pipeline last accepted.
    assign iload     = ihit ? rdata_q : iload_q;
    assign dload     = (dhit && !write_q) ? rdata_q : dload_q;
    assign ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign ram_wdata = wdata_q;

endmodule
